execute_stage: RTL



---
 rtl/lc3_pkg.sv | 47 ++++
 rtl/execute_alu.sv | 26 ++
 rtl/execute_stage.sv | 122 ++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 constants for the execute stage: opcodes, control-field encodings
// and the bit positions of the packed E_Control bus.
package lc3_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_AND  = 2'd1,
    ALU_NOT  = 2'd2,
    ALU_HOLD = 2'd3
  } alu_ctl_e;

  typedef enum logic [1:0] {
    PCSEL1_OFF11 = 2'd0,
    PCSEL1_OFF9  = 2'd1,
    PCSEL1_OFF6  = 2'd2,
    PCSEL1_ZERO  = 2'd3
  } pcsel1_e;

  // E_Control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
  localparam int EC_ALU_HI  = 5;
  localparam int EC_ALU_LO  = 4;
  localparam int EC_PCS1_HI = 3;
  localparam int EC_PCS1_LO = 2;
  localparam int EC_PCS2    = 1;
  localparam int EC_OP2SEL  = 0;

  function automatic logic is_store_op(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STI) || (op == OP_STR);
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/execute_alu.sv
// Combinational LC-3 ALU: ADD, AND, NOT. The hold encoding produces zero here;
// the execute stage suppresses the aluout write for it.
module execute_alu
  import lc3_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] op2,
  input  alu_ctl_e      alu_control,
  output logic [DW-1:0] result
);

  always_comb begin
    // NOTE: a default assignment ahead of the case keeps every path driven,
    // so no latch is inferred for result.
    result = '0;
    case (alu_control)
      ALU_ADD: result = a + op2;
      ALU_AND: result = a & op2;
      ALU_NOT: result = ~a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// LC-3 execute stage: operand selection, ALU, PC-relative address adder and the
// execute/memory pipeline registers. Operand bypass is built only when
// EXECUTE_BYPASS_EN is defined; otherwise the bypass inputs are ignored.
module execute_stage
  import lc3_pkg::*;
#(
  parameter int DW = 16,  // fixed by the ISA
  parameter int RA = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable_execute,
  input  logic [5:0]    E_Control,
  input  logic [1:0]    W_Control_in,
  input  logic          Mem_Control_in,
  input  logic [DW-1:0] IR,
  input  logic [DW-1:0] npc_in,
  input  logic [DW-1:0] VSR1,
  input  logic [DW-1:0] VSR2,
  input  logic [DW-1:0] Mem_Bypass_Val,
  input  logic          bypass_alu_1,
  input  logic          bypass_alu_2,
  input  logic          bypass_mem_1,
  input  logic          bypass_mem_2,
  output logic [RA-1:0] sr1,
  output logic [RA-1:0] sr2,
  output logic [DW-1:0] aluout,
  output logic [DW-1:0] pcout,
  output logic [RA-1:0] dr,
  output logic [1:0]    W_Control_out,
  output logic          Mem_Control_out,
  output logic [DW-1:0] M_Data,
  output logic [2:0]    NZP,
  output logic [DW-1:0] IR_Exec
);

  logic [3:0]    opcode;
  alu_ctl_e      alu_ctl;
  pcsel1_e       pcsel1;
  logic [DW-1:0] operand_a;
  logic [DW-1:0] operand_b;
  logic [DW-1:0] op2;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] pc_offset;
  logic [DW-1:0] pc_base;
  logic [DW-1:0] pc_sum;

  assign opcode  = IR[15:12];
  assign alu_ctl = alu_ctl_e'(E_Control[EC_ALU_HI:EC_ALU_LO]);
  assign pcsel1  = pcsel1_e'(E_Control[EC_PCS1_HI:EC_PCS1_LO]);

  // Stores read the source register through the second port.
  assign sr1 = IR[8:6];
  assign sr2 = is_store_op(opcode) ? IR[11:9] : IR[2:0];

`ifdef EXECUTE_BYPASS_EN
  // ALU forwarding is younger than memory forwarding, so it wins.
  always_comb begin
    operand_a = VSR1;
    if (bypass_alu_1)      operand_a = aluout;
    else if (bypass_mem_1) operand_a = Mem_Bypass_Val;
    operand_b = VSR2;
    if (bypass_alu_2)      operand_b = aluout;
    else if (bypass_mem_2) operand_b = Mem_Bypass_Val;
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{bypass_alu_1, bypass_alu_2, bypass_mem_1,
                           bypass_mem_2, Mem_Bypass_Val};
  assign operand_a = VSR1;
  assign operand_b = VSR2;
`endif

  assign op2 = E_Control[EC_OP2SEL] ? {{(DW-5){IR[4]}}, IR[4:0]} : operand_b;

  execute_alu #(.DW(DW)) u_alu (
    .a           (operand_a),
    .op2         (op2),
    .alu_control (alu_ctl),
    .result      (alu_result)
  );

  always_comb begin
    pc_offset = '0;
    case (pcsel1)
      PCSEL1_OFF11: pc_offset = {{(DW-11){IR[10]}}, IR[10:0]};
      PCSEL1_OFF9:  pc_offset = {{(DW-9){IR[8]}},   IR[8:0]};
      PCSEL1_OFF6:  pc_offset = {{(DW-6){IR[5]}},   IR[5:0]};
      default:      pc_offset = '0;
    endcase
  end

  assign pc_base = E_Control[EC_PCS2] ? npc_in : operand_a;
  assign pc_sum  = pc_base + pc_offset;

  // NOTE: every pipeline register is reset; there is no storage array here,
  // so clearing all state on reset costs nothing and keeps outputs defined.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aluout          <= '0;
      pcout           <= '0;
      dr              <= '0;
      W_Control_out   <= '0;
      Mem_Control_out <= 1'b0;
      M_Data          <= '0;
      NZP             <= '0;
      IR_Exec         <= '0;
    end else if (enable_execute) begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values, including aluout when it feeds back through the bypass.
      if (is_alu_op(opcode) && (alu_ctl != ALU_HOLD)) aluout <= alu_result;
      if (!is_alu_op(opcode))  pcout  <= pc_sum;
      if (is_store_op(opcode)) M_Data <= operand_b;
      dr              <= IR[11:9];
      W_Control_out   <= W_Control_in;
      Mem_Control_out <= Mem_Control_in;
      NZP             <= (opcode == OP_BR) ? IR[11:9] : 3'b000;
      IR_Exec         <= IR;
    end
  end

endmodule
